d7_scan_controller: RTL and testbench



---
 rtl/d7_pkg.sv | 19 +
 rtl/d7_char_buffer.sv | 36 +++
 rtl/d7_scan_controller.sv | 130 +++++++++++++
 tb/tb_d7_scan_controller.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/d7_pkg.sv
// Shared types and seven-segment character codes for the d7 scan controller.
// Cathode codes are active-low {dp,g,f,e,d,c,b,a}.
package d7_pkg;
    localparam logic [7:0] CHAR_BLANK = 8'hFF;
    localparam logic [7:0] CHAR_U     = 8'b1100_0001;
    localparam logic [7:0] CHAR_L     = 8'b1100_0111;
    localparam logic [7:0] CHAR_0     = 8'hC0;
    localparam logic [7:0] CHAR_1     = 8'hF9;
    localparam logic [7:0] CHAR_2     = 8'hA4;
    localparam logic [7:0] CHAR_3     = 8'hB0;
    localparam logic [7:0] CHAR_4     = 8'h99;
    localparam logic [7:0] CHAR_5     = 8'h92;
    localparam logic [7:0] CHAR_6     = 8'h82;
    localparam logic [7:0] CHAR_7     = 8'hF8;
    localparam logic [7:0] CHAR_8     = 8'h80;
    localparam logic [7:0] CHAR_9     = 8'h90;

    typedef enum logic {BLANK, SHOW} state_t;
endpackage

// File: rtl/d7_char_buffer.sv
// Shadow/active character storage: requesters write the shadow copy, and the
// whole shadow is copied to the active copy on commit. Reads come from active.
module d7_char_buffer
    import d7_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int IW       = $clog2(N_DIGITS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          commit,
    input  logic [IW-1:0] rd_idx,
    output logic [7:0]    rd_data
);
    logic [N_DIGITS-1:0][7:0] shadow;
    logic [N_DIGITS-1:0][7:0] active;

    // A write landing on the commit edge only reaches shadow; active takes the
    // pre-write shadow because both are non-blocking updates on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow <= {N_DIGITS{CHAR_BLANK}};
            active <= {N_DIGITS{CHAR_BLANK}};
        end else begin
            if (commit)
                active <= shadow;
            if (wr_en)
                shadow[wr_addr] <= wr_data;
        end
    end

    assign rd_data = active[rd_idx];
endmodule

// File: rtl/d7_scan_controller.sv
// Eight-digit seven-segment scan controller with blanking gaps and
// frame-aligned commit. Optional brightness control under D7_SCAN_DIMMING_EN.
module d7_scan_controller
    import d7_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 100,
    parameter int IW           = $clog2(N_DIGITS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_addr,
    input  logic [7:0]          wr_data,
    input  logic                commit_req,
    output logic                commit_ack,
    input  logic [N_DIGITS-1:0] digit_en,
`ifdef D7_SCAN_DIMMING_EN
    input  logic [3:0]          brightness,
`endif
    output logic                frame_sync,
    output logic [N_DIGITS-1:0] d7_anodes,
    output logic [7:0]          d7_cathodes
);
    localparam int SW = $clog2(PRESCALE);
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [SW-1:0] SHOW_LAST  = SW'(PRESCALE - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    state_t              state, state_n;
    logic [IW-1:0]       idx, idx_n;
    logic [SW-1:0]       show_cnt, show_n;
    logic [BW-1:0]       blank_cnt, blank_n;
    logic                wrap;
    logic                lit;
    logic [7:0]          rd_data;
    logic [N_DIGITS-1:0] anode_n;
    logic [7:0]          cath_n;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        show_n  = show_cnt;
        blank_n = blank_cnt;
        wrap    = 1'b0;
        case (state)
            BLANK: begin
                if (blank_cnt == BLANK_LAST) begin
                    state_n = SHOW;
                    blank_n = '0;
                end else begin
                    blank_n = blank_cnt + 1'b1;
                end
            end
            SHOW: begin
                if (show_cnt == SHOW_LAST) begin
                    state_n = BLANK;
                    show_n  = '0;
                    wrap    = (idx == IDX_LAST);
                    idx_n   = wrap ? '0 : idx + 1'b1;
                end else begin
                    show_n = show_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef D7_SCAN_DIMMING_EN
    logic [3:0] bright_q;

    // show_n is 0 on entry to SHOW, so the stale bright_q never matters there.
    always_comb lit = (int'(show_n) < (int'(bright_q) + 1) * (PRESCALE / 16));

    always_ff @(posedge clk) begin
        if (!reset_n)
            bright_q <= '0;
        else if (state == BLANK && state_n == SHOW)
            bright_q <= brightness;
    end
`else
    always_comb lit = 1'b1;
`endif

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin
        anode_n = '0;
        cath_n  = CHAR_BLANK;
        if (state_n == SHOW && digit_en[idx_n]) begin
            cath_n = rd_data;
            if (lit)
                anode_n[idx_n] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= BLANK;
            idx         <= '0;
            show_cnt    <= '0;
            blank_cnt   <= '0;
            d7_anodes   <= '0;
            d7_cathodes <= CHAR_BLANK;
            commit_ack  <= 1'b0;
            frame_sync  <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            show_cnt    <= show_n;
            blank_cnt   <= blank_n;
            d7_anodes   <= anode_n;
            d7_cathodes <= cath_n;
            commit_ack  <= wrap && commit_req;
            frame_sync  <= wrap;
        end
    end

    d7_char_buffer #(.N_DIGITS(N_DIGITS), .IW(IW)) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .commit  (wrap && commit_req),
        .rd_idx  (idx_n),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_d7_scan_controller.sv
// Self-checking bench for d7_scan_controller: timeline model feeding a
// per-cycle scoreboard, a vector table, and hand-written corner sequences.
module tb_d7_scan_controller;
    import d7_pkg::*;

    localparam int B = 1;
`ifdef D7_SCAN_DIMMING_EN
    localparam int P = 16;
`else
    localparam int P = 4;
`endif
    localparam int SLOT  = P + B;
    localparam int FRAME = 8 * SLOT;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       commit_req = 1'b0;
    logic [7:0] digit_en = 8'hFF;
    logic       commit_ack, frame_sync;
    logic [7:0] d7_anodes, d7_cathodes;
`ifdef D7_SCAN_DIMMING_EN
    logic [3:0] brightness = 4'hF;
`endif

    d7_scan_controller #(.N_DIGITS(8), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit_req  (commit_req),
        .commit_ack  (commit_ack),
        .digit_en    (digit_en),
`ifdef D7_SCAN_DIMMING_EN
        .brightness  (brightness),
`endif
        .frame_sync  (frame_sync),
        .d7_anodes   (d7_anodes),
        .d7_cathodes (d7_cathodes)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [17:0] exp_q[$];
    int t = 0;
    logic [7:0] m_shadow[8];
    logic [7:0] m_active[8];
    int m_bright = 15;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        logic       commit;
        logic [7:0] en;
        logic [7:0] exp_an;
        logic [7:0] exp_ca;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0d)", name, act, exp, t);
        end
    endtask

    // One clock: advance the spec model with the inputs seen at this edge and
    // queue the outputs expected during the cycle that follows.
    task automatic tick();
        int tn, pos, dig, on_len;
        logic bnd;
        logic [7:0] an, ca;
        @(posedge clk);
        if (!reset_n) begin
            t = 0;
            for (int i = 0; i < 8; i++) begin
                m_shadow[i] = 8'hFF;
                m_active[i] = 8'hFF;
            end
            exp_q.push_back({8'h00, 8'hFF, 2'b00});
        end else begin
            tn  = t + 1;
            bnd = (tn % FRAME == 0);
            pos = tn % SLOT;
            dig = (tn / SLOT) % 8;
            if (bnd && commit_req)
                m_active = m_shadow;
            if (wr_en)
                m_shadow[wr_addr] = wr_data;
            on_len = P;
`ifdef D7_SCAN_DIMMING_EN
            if (pos == B)
                m_bright = int'(brightness);
            on_len = (m_bright + 1) * (P / 16);
`endif
            an = 8'h00;
            ca = 8'hFF;
            if (pos >= B && digit_en[dig]) begin
                ca = m_active[dig];
                if (pos - B < on_len)
                    an[dig] = 1'b1;
            end
            exp_q.push_back({an, ca, bnd && commit_req, bnd});
            t = tn;
        end
        #1;
    endtask

    task automatic run_to(input int pos);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((t % FRAME) != pos && n <= FRAME);
    endtask

    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", {14'd0, d7_anodes, d7_cathodes, commit_ack, frame_sync}, {14'd0, e});
            end
        end
    end

    initial begin
        int first_an, first_sync, n, cnt, acks, nonff;

        vecs[0] = '{3'd4, 8'hC7,  1'b1, 8'hFF, 8'h10, 8'hC7};
        vecs[1] = '{3'd5, 8'hC1,  1'b1, 8'hFF, 8'h20, 8'hC1};
        vecs[2] = '{3'd4, 8'hC0,  1'b0, 8'hFF, 8'h10, 8'hC7};
        vecs[3] = '{3'd4, 8'hC0,  1'b0, 8'hFF, 8'h10, 8'hC7};
        vecs[4] = '{3'd4, CHAR_0, 1'b1, 8'hEF, 8'h00, 8'hFF};
        vecs[5] = '{3'd4, CHAR_0, 1'b1, 8'hFF, 8'h10, 8'hC0};
        vecs[6] = '{3'd0, CHAR_1, 1'b1, 8'hFF, 8'h01, 8'hF9};
        vecs[7] = '{3'd7, CHAR_L, 1'b1, 8'hFF, 8'h80, 8'hC7};

        repeat (3) begin
            tick();
            check("rst_an", {24'd0, d7_anodes}, 32'h00);
            check("rst_ca", {24'd0, d7_cathodes}, 32'hFF);
        end
        reset_n = 1'b1;

        first_an = -1;
        first_sync = -1;
        while (t < FRAME) begin
            tick();
            if (t == 1) begin
                check("c1_an", {24'd0, d7_anodes}, 32'h01);
                check("c1_ca", {24'd0, d7_cathodes}, 32'hFF);
            end
            if (d7_anodes != 0 && first_an < 0) first_an = t;
            if (frame_sync && first_sync < 0) first_sync = t;
        end
        check("first_anode", first_an, B);
        check("first_sync", first_sync, FRAME);

        for (int i = 0; i < 8; i++) begin
            digit_en = vecs[i].en;
            wr_en = 1'b1;
            wr_addr = vecs[i].addr;
            wr_data = vecs[i].data;
            tick();
            wr_en = 1'b0;
            commit_req = vecs[i].commit;
            run_to(0);
            check($sformatf("ack%0d", i), {31'd0, commit_ack}, {31'd0, vecs[i].commit});
            commit_req = 1'b0;
            run_to(vecs[i].addr * SLOT + B);
            check($sformatf("an%0d", i), {24'd0, d7_anodes}, {24'd0, vecs[i].exp_an});
            check($sformatf("ca%0d", i), {24'd0, d7_cathodes}, {24'd0, vecs[i].exp_ca});
        end

        // write on the copy edge: active must take the pre-write shadow
        run_to(FRAME - 1);
        commit_req = 1'b1;
        wr_en = 1'b1;
        wr_addr = 3'd2;
        wr_data = CHAR_2;
        tick();
        check("ack_wr", {31'd0, commit_ack}, 32'd1);
        wr_en = 1'b0;
        commit_req = 1'b0;
        run_to(2 * SLOT + B);
        check("prewrite_copy", {24'd0, d7_cathodes}, 32'hFF);
        commit_req = 1'b1;
        run_to(0);
        commit_req = 1'b0;
        run_to(2 * SLOT + B);
        check("late_copy", {24'd0, d7_cathodes}, {24'd0, CHAR_2});

        // disabled digit keeps its slot
        digit_en = 8'hEF;
        run_to(0);
        n = 0;
        cnt = 0;
        do begin
            tick();
            n++;
            if (d7_anodes != 0) cnt++;
        end while (!frame_sync && n < 2 * FRAME);
        check("frame_len_en", n, FRAME);
        check("lit_cycles_en", cnt, 7 * P);
        digit_en = 8'hFF;

`ifdef D7_SCAN_DIMMING_EN
        brightness = 4'd0;
        run_to(0);
        cnt = 0;
        repeat (SLOT) begin
            tick();
            if (d7_anodes[0]) cnt++;
        end
        check("dim_b0", cnt, 1);
        brightness = 4'd15;
        run_to(0);
        cnt = 0;
        repeat (SLOT) begin
            tick();
            if (d7_anodes[0]) cnt++;
        end
        check("dim_b15", cnt, 16);
`endif

        // reset mid-frame with a commit pending
        commit_req = 1'b1;
        run_to(13);
        reset_n = 1'b0;
        tick();
        check("midrst_an", {24'd0, d7_anodes}, 32'h00);
        check("midrst_ca", {24'd0, d7_cathodes}, 32'hFF);
        tick();
        reset_n = 1'b1;
        commit_req = 1'b0;
        acks = 0;
        nonff = 0;
        repeat (FRAME + 1) begin
            tick();
            if (commit_ack) acks++;
            if (d7_cathodes != 8'hFF) nonff++;
        end
        check("rst_no_ack", acks, 0);
        check("rst_active_ff", nonff, 0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
